freepdk45_sram_1w1r_pipe: RTL

//  Parametrised single-clock 1W1R SRAM model, successor to the fixed 96x32 1w1r macros.

---
 rtl/freepdk45_sram_1w1r_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/freepdk45_sram_1w1r_pipe.sv
// Behavioural 1W1R SRAM with byte masks, write-first forwarding, a 1/2-stage read pipeline
// and a reset-time clear sequencer that zeroes the array before the ports are served.
module freepdk45_sram_1w1r_pipe #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned RAM_DEPTH      = 96,
    parameter int unsigned NUM_WMASKS     = DATA_WIDTH / 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  init_busy,
    output logic                  collision,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {StReady, StClear} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic                    ready;
    logic                    wr_in, rd_in;
    logic                    wr_acc, rd_acc;
    logic                    wr_ok, rd_ok;
    logic                    wr_oor, rd_oor;
    logic                    fwd;
    logic [DATA_WIDTH-1:0]   wr_word, rd_word;

    logic                    s1_vld_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic                    s1_coll_q, s1_err_q;

    logic                    last_vld, last_coll, last_err;
    logic [DATA_WIDTH-1:0]   last_data;

    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    vld_q, coll_q, err_q;

    // Clear sequencer
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == StClear) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
                state_d   = StReady;
                clr_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StReady;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Port decode
    assign ready  = (state_q == StReady);
    assign wr_in  = ({1'b0, addr0} < DEPTH_W);
    assign rd_in  = ({1'b0, addr1} < DEPTH_W);
    assign wr_acc = ready & ~csb0;
    assign rd_acc = ready & ~csb1;
    assign wr_ok  = wr_acc & wr_in;
    assign rd_ok  = rd_acc & rd_in;
    assign wr_oor = wr_acc & ~wr_in;
    assign rd_oor = rd_acc & ~rd_in;
    assign fwd    = wr_ok & rd_ok & (addr0 == addr1);

    // Merged write word; a same-address read sees the same merge (write-first)
    always_comb begin
        wr_word = mem_q[addr0];
        rd_word = rd_in ? mem_q[addr1] : '0;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
                wr_word[8*i +: 8] = din0[8*i +: 8];
                if (fwd) begin
                    rd_word[8*i +: 8] = din0[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (state_q == StClear) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_ok) begin
                mem_q[addr0] <= wr_word;
            end
        end
    end

    // Read pipeline; stage 1 is bypassed when READ_LATENCY is 1
    always_comb begin
        if (READ_LATENCY == 2) begin
            last_vld  = s1_vld_q;
            last_data = s1_data_q;
            last_coll = s1_coll_q;
            last_err  = s1_err_q;
        end else begin
            last_vld  = rd_acc;
            last_data = rd_word;
            last_coll = fwd;
            last_err  = rd_oor;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_coll_q <= 1'b0;
            s1_err_q  <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            coll_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s1_vld_q  <= rd_acc;
            s1_data_q <= rd_word;
            s1_coll_q <= fwd;
            s1_err_q  <= rd_oor;
            vld_q     <= last_vld;
            if (last_vld) begin
                dout_q <= last_data;
            end
            coll_q    <= last_vld & last_coll;
            // Read and write range errors landing on the same edge merge into one pulse
            err_q     <= (last_vld & last_err) | wr_oor;
        end
    end

    assign dout1       = dout_q;
    assign dout1_valid = vld_q;
    assign collision   = coll_q;
    assign addr_err    = err_q;
    assign init_busy   = (state_q == StClear);

endmodule
